lcd_ctrl_gen: RTL and testbench
===============================

LCD_CTRL_GEN -- requirements
Module: lcd_ctrl_gen

Interface
REQ-001 Parameter BUS_WIDTH, default 4, LCD data bus width; legal values 4 (nibble mode) or 8 (byte mode).
REQ-002 Parameter T_AS, default 1, address setup cycles: RS/RW/data valid before enable rises; minimum 1.
REQ-003 Parameter T_PW, default 5, enable-high cycles; minimum 1.
REQ-004 Parameter T_H, default 1, hold cycles after enable falls; minimum 1.
REQ-005 Parameter T_EXEC, default 400, post-transfer execution wait in cycles for normal commands/data.
REQ-006 Parameter T_LONG, default 16400, execution wait for clear/home commands.
REQ-007 clk  in  1  single clock; all logic on rising edge.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 rs_in, rw_in  in  1 each  register select and read/write (1 = read) of the requested transfer.
REQ-010 data_in  in  8  write byte.
REQ-011 start  in  1  request; accepted only when ready=1.
REQ-012 ready  out  1  controller idle and able to accept start.
REQ-013 done  out  1  one-cycle pulse on transfer completion.
REQ-014 rd_data  out  8  byte captured by the last read; held until the next read completes.
REQ-015 rs_out, rw_out, enable_out  out  1 each  LCD RS, R/W, E.
REQ-016 data_out  out  BUS_WIDTH  LCD data driven on writes.
REQ-017 data_oe  out  1  1 = controller drives the LCD bus.
REQ-018 lcd_data_in  in  BUS_WIDTH  LCD bus sampled on reads.

Function
REQ-019 FSM states: IDLE, SETUP, EN_HIGH, HOLD, WAIT; ready=1 only in IDLE.
REQ-020 In IDLE with start=1: latch rs_in, rw_in, data_in; next state SETUP; ready falls the following cycle.
REQ-021 Transfer units: one byte per transfer for BUS_WIDTH=8; two nibbles for BUS_WIDTH=4, high nibble first.
REQ-022 Per unit: SETUP for T_AS cycles (enable_out=0), EN_HIGH for T_PW cycles (enable_out=1), HOLD for T_H cycles (enable_out=0); rs_out/rw_out/data_out are stable across all three.
REQ-023 After HOLD of the first nibble in 4-bit mode -> SETUP with the low nibble; after the last unit -> WAIT.
REQ-024 Writes: data_oe=1 and data_out = current unit from SETUP through HOLD; rw_out=0.
REQ-025 Reads: data_oe=0, rw_out=1, data_out=0; lcd_data_in sampled on the last EN_HIGH cycle of each unit; rd_data updated at the end of the last unit.
REQ-026 WAIT lasts T_LONG cycles when rs=0, rw=0 and data in {0x01, 0x02, 0x03}; otherwise T_EXEC cycles; T_EXEC=0 skips WAIT.
REQ-027 On leaving WAIT (or the last HOLD): enter IDLE with done=1 for exactly that first IDLE cycle; start is accepted in that cycle (back-to-back).
REQ-028 ready is low for exactly units*(T_AS+T_PW+T_H)+wait cycles per transfer.
REQ-029 start while ready=0 is ignored: no latch, no queueing.
REQ-030 In IDLE: rs_out=0, rw_out=0, enable_out=0, data_out=0, data_oe=0.
REQ-031 Phase counter sized to clog2 of max(T_PW, T_AS, T_H, T_EXEC, T_LONG)+1; counts down to 1 and never wraps.

Reset
REQ-032 While rst=1 at a clock edge: state=IDLE, ready=1, done=0, enable_out=0, rs_out=0, rw_out=0, data_out=0, data_oe=0, rd_data=0x00, counters=0; start is ignored.
REQ-033 rst in any state, including mid-pulse, aborts the transfer; enable_out is 0 in the cycle after the reset edge; no done is generated for the aborted transfer.

Verification (defaults, BUS_WIDTH=4 unless noted)
REQ-034 Write rs=1, data=0xA5 -> enable pulses twice (5 cycles each); data_out=0xA then 0x5; data_oe=1; ready low 414 cycles; one done pulse.
REQ-035 Write rs=0, data=0x01 -> ready low 14+16400=16414 cycles; then done.
REQ-036 BUS_WIDTH=8, write rs=1, data=0x33 -> single enable pulse, data_out=0x33, ready low 407 cycles.
REQ-037 Read rs=0 with lcd_data_in=0x8 on nibble 1 and 0x0 on nibble 2 -> rw_out=1, data_oe=0, rd_data=0x80 at done.
REQ-038 start pulsed during EN_HIGH -> ignored, single transfer; start held at done -> second transfer begins with no idle gap.
REQ-039 rst asserted on the 3rd EN_HIGH cycle -> enable_out=0 on the next cycle, ready=1, no done pulse, all outputs at reset values.

Source files
------------

// File: rtl/lcd_ctrl_gen.sv
// HD44780-style LCD bus controller: sequences RS/RW/E timing for one byte
// transfer (one byte in 8-bit mode, two nibbles high-first in 4-bit mode),
// then waits out the LCD execution time before returning to idle.
module lcd_ctrl_gen #(
  parameter int BUS_WIDTH = 4,
  parameter int T_AS      = 1,
  parameter int T_PW      = 5,
  parameter int T_H       = 1,
  parameter int T_EXEC    = 400,
  parameter int T_LONG    = 16400
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rs_in,
  input  logic                 rw_in,
  input  logic [7:0]           data_in,
  input  logic                 start,
  output logic                 ready,
  output logic                 done,
  output logic [7:0]           rd_data,
  output logic                 rs_out,
  output logic                 rw_out,
  output logic                 enable_out,
  output logic [BUS_WIDTH-1:0] data_out,
  output logic                 data_oe,
  input  logic [BUS_WIDTH-1:0] lcd_data_in
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int UNITS = (BUS_WIDTH == 8) ? 1 : 2;
  localparam int T_MAX = max2(max2(max2(T_AS, T_PW), max2(T_H, T_EXEC)), T_LONG);
  localparam int CNT_W = $clog2(T_MAX + 1);

  typedef enum logic [2:0] {IDLE, SETUP, EN_HIGH, HOLD, WAIT} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               unit_q;
  logic               rs_q, rw_q;
  logic [7:0]         data_q;
  logic [7:0]         rd_shift;
  logic               cnt_last;
  logic               last_unit;
  logic               long_cmd;
  logic [CNT_W-1:0]   wait_len;
  logic [7:0]         unit_byte;
  logic [BUS_WIDTH-1:0] unit_data;

  assign cnt_last  = (cnt == CNT_W'(1));
  assign last_unit = (UNITS == 1) || unit_q;
  // Clear display / return home need the long execution delay.
  assign long_cmd  = !rs_q && !rw_q &&
                     (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);
  assign wait_len  = long_cmd ? CNT_W'(T_LONG) : CNT_W'(T_EXEC);
  assign unit_byte = (UNITS == 2 && !unit_q) ? (data_q >> 4) : data_q;
  assign unit_data = unit_byte[BUS_WIDTH-1:0];

  // State, phase counter and done pulse register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      done  <= (state_nx == IDLE) && (state != IDLE);
    end
  end

  // Next-state and phase-counter reload; counter saturates at 1 within a phase.
  always_comb begin
    state_nx = state;
    cnt_nx   = (cnt > CNT_W'(1)) ? cnt - CNT_W'(1) : cnt;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (start) begin
          state_nx = SETUP;
          cnt_nx   = CNT_W'(T_AS);
        end
      end
      SETUP: begin
        if (cnt_last) begin
          state_nx = EN_HIGH;
          cnt_nx   = CNT_W'(T_PW);
        end
      end
      EN_HIGH: begin
        if (cnt_last) begin
          state_nx = HOLD;
          cnt_nx   = CNT_W'(T_H);
        end
      end
      HOLD: begin
        if (cnt_last) begin
          if (!last_unit) begin
            state_nx = SETUP;
            cnt_nx   = CNT_W'(T_AS);
          end else if (wait_len == '0) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else begin
            state_nx = WAIT;
            cnt_nx   = wait_len;
          end
        end
      end
      WAIT: begin
        if (cnt_last) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Request latch, nibble index and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      rs_q     <= 1'b0;
      rw_q     <= 1'b0;
      data_q   <= 8'h00;
      unit_q   <= 1'b0;
      rd_shift <= 8'h00;
      rd_data  <= 8'h00;
    end else begin
      if (state == IDLE && start) begin
        rs_q   <= rs_in;
        rw_q   <= rw_in;
        data_q <= data_in;
        unit_q <= 1'b0;
      end
      if (state == HOLD && cnt_last && !last_unit)
        unit_q <= 1'b1;
      if (state == EN_HIGH && cnt_last && rw_q)
        rd_shift <= (rd_shift << BUS_WIDTH) | 8'(lcd_data_in);
      if (state == HOLD && cnt_last && last_unit && rw_q)
        rd_data <= rd_shift;
    end
  end

  // LCD pin drive: active only while a unit is on the bus.
  always_comb begin
    ready      = (state == IDLE);
    rs_out     = 1'b0;
    rw_out     = 1'b0;
    enable_out = 1'b0;
    data_out   = '0;
    data_oe    = 1'b0;
    if (state == SETUP || state == EN_HIGH || state == HOLD) begin
      rs_out     = rs_q;
      rw_out     = rw_q;
      enable_out = (state == EN_HIGH);
      data_oe    = !rw_q;
      data_out   = rw_q ? '0 : unit_data;
    end
  end

endmodule

// File: tb/tb_lcd_ctrl_gen.sv
// Directed bench for lcd_ctrl_gen: 4-bit instance for most transfers plus an
// 8-bit instance for byte mode.
module tb_lcd_ctrl_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rs_in = 1'b0, rw_in = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       start = 1'b0;
  logic       ready, done, rs_out, rw_out, enable_out, data_oe;
  logic [7:0] rd_data;
  logic [3:0] data_out;
  logic [3:0] lcd_data_in = 4'h0;

  logic       start8 = 1'b0;
  logic       ready8, done8, rs8, rw8, en8, oe8;
  logic [7:0] rd_data8, data_out8;
  logic [7:0] lcd8 = 8'h00;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lcd_ctrl_gen #(.BUS_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .rs_in(rs_in), .rw_in(rw_in), .data_in(data_in),
    .start(start), .ready(ready), .done(done), .rd_data(rd_data),
    .rs_out(rs_out), .rw_out(rw_out), .enable_out(enable_out),
    .data_out(data_out), .data_oe(data_oe), .lcd_data_in(lcd_data_in)
  );

  lcd_ctrl_gen #(.BUS_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .rs_in(rs_in), .rw_in(rw_in), .data_in(data_in),
    .start(start8), .ready(ready8), .done(done8), .rd_data(rd_data8),
    .rs_out(rs8), .rw_out(rw8), .enable_out(en8),
    .data_out(data_out8), .data_oe(oe8), .lcd_data_in(lcd8)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one transfer on the 4-bit instance from an IDLE cycle and observes
  // it until ready returns; returns in the first IDLE (done) cycle.
  task automatic xfer(input logic rs, input logic rw, input logic [7:0] d,
                      input logic [3:0] rhi, input logic [3:0] rlo, input bit poke,
                      output int low, output int pulses, output int enc,
                      output logic [3:0] d0, output logic [3:0] d1,
                      output bit oe_bad, output bit pin_bad);
    logic prev_en;
    low = 0; pulses = 0; enc = 0; d0 = 4'hx; d1 = 4'hx;
    oe_bad = 1'b0; pin_bad = 1'b0; prev_en = 1'b0;
    rs_in = rs; rw_in = rw; data_in = d; lcd_data_in = rhi;
    start = 1'b1;
    tick;
    start = 1'b0;
    while (!ready && low < 20000) begin
      low++;
      if (enable_out) begin
        enc++;
        if (!prev_en) begin
          pulses++;
          if (pulses == 1) d0 = data_out;
          else d1 = data_out;
        end
        if (data_oe !== !rw) oe_bad = 1'b1;
        if (rw && data_out !== 4'h0) oe_bad = 1'b1;
        if (rs_out !== rs || rw_out !== rw) pin_bad = 1'b1;
      end
      start = (poke && enable_out && enc == 3);
      if (start) begin
        data_in = 8'h3C;
        rs_in   = 1'b0;
      end
      lcd_data_in = (pulses <= 1) ? rhi : rlo;
      prev_en = enable_out;
      tick;
    end
    start = 1'b0;
  endtask

  int         low, pulses, enc;
  logic [3:0] d0, d1;
  bit         oe_bad, pin_bad;

  initial begin
    // Reset with a start request that must be ignored.
    start = 1'b1;
    tick;
    tick;
    start = 1'b0;
    rst = 1'b0;
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_enable", enable_out, 0);
    check("rst_oe", data_oe, 0);
    check("rst_data_out", data_out, 0);
    check("rst_rs_rw", {rs_out, rw_out}, 0);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_rd_data8", rd_data8, 8'h00);
    tick;
    check("rst_idle_ready", ready, 1);

    // Data write 0xA5: two nibbles, normal execution wait.
    xfer(1'b1, 1'b0, 8'hA5, 4'h0, 4'h0, 1'b0, low, pulses, enc, d0, d1, oe_bad, pin_bad);
    check("wr_a5_low", low, 414);
    check("wr_a5_pulses", pulses, 2);
    check("wr_a5_en_cycles", enc, 10);
    check("wr_a5_nib_hi", d0, 4'hA);
    check("wr_a5_nib_lo", d1, 4'h5);
    check("wr_a5_oe", oe_bad, 0);
    check("wr_a5_pins", pin_bad, 0);
    check("wr_a5_done", done, 1);
    tick;
    check("wr_a5_done_clr", done, 0);

    // Clear display: long execution wait.
    xfer(1'b0, 1'b0, 8'h01, 4'h0, 4'h0, 1'b0, low, pulses, enc, d0, d1, oe_bad, pin_bad);
    check("clr_low", low, 16414);
    check("clr_nibs", {d0, d1}, 8'h01);
    check("clr_done", done, 1);
    tick;

    // Command 0x04 is not a long command.
    xfer(1'b0, 1'b0, 8'h04, 4'h0, 4'h0, 1'b0, low, pulses, enc, d0, d1, oe_bad, pin_bad);
    check("cmd04_low", low, 414);
    tick;

    // Reads: nibbles assembled high first.
    xfer(1'b0, 1'b1, 8'h00, 4'h8, 4'h0, 1'b0, low, pulses, enc, d0, d1, oe_bad, pin_bad);
    check("rd80_oe_pins", oe_bad, 0);
    check("rd80_rw", pin_bad, 0);
    check("rd80_data", rd_data, 8'h80);
    check("rd80_done", done, 1);
    tick;
    // Read with data_in=0x01 latched: rw=1 keeps the normal wait.
    xfer(1'b0, 1'b1, 8'h01, 4'h3, 4'hC, 1'b0, low, pulses, enc, d0, d1, oe_bad, pin_bad);
    check("rd3c_data", rd_data, 8'h3C);
    check("rd3c_low", low, 414);
    tick;
    check("rd_hold", rd_data, 8'h3C);

    // start during EN_HIGH is ignored and not queued.
    xfer(1'b1, 1'b0, 8'hA5, 4'h0, 4'h0, 1'b1, low, pulses, enc, d0, d1, oe_bad, pin_bad);
    check("poke_low", low, 414);
    check("poke_nib_lo", d1, 4'h5);
    check("poke_done", done, 1);
    tick;
    check("poke_no_queue", ready, 1);

    // Back-to-back: second start in the done cycle.
    xfer(1'b1, 1'b0, 8'h12, 4'h0, 4'h0, 1'b0, low, pulses, enc, d0, d1, oe_bad, pin_bad);
    check("b2b_first_done", done, 1);
    xfer(1'b1, 1'b0, 8'h5A, 4'h0, 4'h0, 1'b0, low, pulses, enc, d0, d1, oe_bad, pin_bad);
    check("b2b_second_low", low, 414);
    check("b2b_second_nibs", {d0, d1}, 8'h5A);
    tick;

    // Byte mode: single enable pulse carrying the whole byte.
    begin
      int   low8, pulses8;
      logic prev8;
      logic [7:0] byte8;
      low8 = 0; pulses8 = 0; prev8 = 1'b0; byte8 = 8'hxx;
      rs_in = 1'b1; rw_in = 1'b0; data_in = 8'h33;
      start8 = 1'b1;
      tick;
      start8 = 1'b0;
      while (!ready8 && low8 < 20000) begin
        low8++;
        if (en8 && !prev8) begin
          pulses8++;
          byte8 = data_out8;
          check("b8_pins", {rs8, rw8, oe8}, 3'b101);
        end
        prev8 = en8;
        tick;
      end
      check("b8_low", low8, 407);
      check("b8_pulses", pulses8, 1);
      check("b8_data", byte8, 8'h33);
      check("b8_done", done8, 1);
      tick;
    end

    // Reset on the third EN_HIGH cycle aborts without done.
    begin
      int n;
      n = 0;
      rs_in = 1'b1; rw_in = 1'b0; data_in = 8'hA5;
      start = 1'b1;
      tick;
      start = 1'b0;
      for (int i = 0; i < 50 && n < 3; i++) begin
        if (enable_out) n++;
        if (n < 3) tick;
      end
      check("abort_reach_en3", n, 3);
      check("abort_en_before", enable_out, 1);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      check("abort_enable", enable_out, 0);
      check("abort_ready", ready, 1);
      check("abort_done", done, 0);
      check("abort_pins", {rs_out, rw_out, data_oe, data_out}, 0);
      tick;
      check("abort_no_done", done, 0);
      check("abort_idle", ready, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
